kiwi_axi_cfg_responder: RTL and testbench

AXI4-Lite responder for the Kiwi SDR receiver. It terminates the PS GP0 register accesses that configure the receiver: control word, RX0-7 phase increments, and waterfall frequency/decimation. It exposes a read/write config word bank and a read-only status bank, such as FIFO fill counts. It sits between the PS AXI interconnect and the DDC/FIFO datapath, all in the aclk domain.

---
 rtl/kiwi_axi_pkg.sv | 26 ++
 rtl/kiwi_axi_wr_join.sv | 64 ++++++
 rtl/kiwi_axi_cfg_responder.sv | 171 +++++++++++++++++
 tb/tb_kiwi_axi_cfg_responder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kiwi_axi_pkg.sv
// Shared AXI4-Lite constants and helpers for the Kiwi config responder.
package kiwi_axi_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Replace only the byte lanes enabled in strb; other lanes keep old_word.
    function automatic logic [AXI_DATA_W-1:0] byte_merge(
        input logic [AXI_DATA_W-1:0] old_word,
        input logic [AXI_DATA_W-1:0] new_word,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/kiwi_axi_wr_join.sv
// Joins the independent AW and W channels into a single commit pulse.
// Each channel has a one-entry holding register; commit fires on the first
// cycle both are full, and both are emptied on that edge.
module kiwi_axi_wr_join
    import kiwi_axi_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [IDX_W-1:0]      aw_idx,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic                  bvalid,
    output logic                  commit,
    output logic [IDX_W-1:0]      commit_idx,
    output logic [AXI_DATA_W-1:0] commit_data,
    output logic [AXI_STRB_W-1:0] commit_strb
);

    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic [AXI_DATA_W-1:0] wdata_reg;
    logic [AXI_STRB_W-1:0] wstrb_reg;

    // Readies depend only on state (never on bready) and are low during reset.
    assign awready = !areset && !aw_held_reg && !bvalid;
    assign wready  = !areset && !w_held_reg  && !bvalid;

    assign commit      = aw_held_reg && w_held_reg;
    assign commit_idx  = aw_idx_reg;
    assign commit_data = wdata_reg;
    assign commit_strb = wstrb_reg;

    // Capture each channel on its handshake; release both once committed.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else if (commit) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= aw_idx;
            end
            if (wvalid && wready) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= wdata;
                wstrb_reg  <= wstrb;
            end
        end
    end

endmodule

// File: rtl/kiwi_axi_cfg_responder.sv
// AXI4-Lite responder for the Kiwi receiver: R/W config bank at the bottom
// of the map, read-only status bank at STS_OFFSET, SLVERR elsewhere.
module kiwi_axi_cfg_responder
    import kiwi_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CFG_WORDS  = 16,
    parameter int STS_WORDS  = 8,
    parameter int STS_OFFSET = 32'h800
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [AXI_DATA_W-1:0]           s_axi_wdata,
    input  logic [AXI_STRB_W-1:0]           s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [AXI_DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [AXI_DATA_W*CFG_WORDS-1:0] cfg_data,
    output logic [CFG_WORDS-1:0]            cfg_wr_stb,
    input  logic [AXI_DATA_W*STS_WORDS-1:0] sts_data
);

    localparam int          IDX_W    = ADDR_WIDTH - 2;
    localparam logic [31:0] CFG_LIM  = 32'(CFG_WORDS);
    localparam logic [31:0] STS_BASE = 32'(STS_OFFSET / 4);
    localparam logic [31:0] STS_LIM  = 32'(STS_OFFSET / 4 + STS_WORDS);

    logic                  commit;
    logic [IDX_W-1:0]      commit_idx;
    logic [AXI_DATA_W-1:0] commit_data;
    logic [AXI_STRB_W-1:0] commit_strb;
    logic [31:0]           wr_idx32;
    logic                  wr_cfg_hit;
    logic [CFG_WORDS-1:0]  wr_sel;
    logic [CFG_WORDS-1:0]  cfg_wr_stb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic [31:0]           rd_idx32;
    logic [AXI_DATA_W-1:0] rd_word;
    logic [1:0]            rd_resp;
    logic                  rvalid_reg;
    logic [AXI_DATA_W-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    // Byte-lane address bits are don't-care for whole-word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    kiwi_axi_wr_join #(
        .IDX_W (IDX_W)
    ) u_wr_join (
        .aclk        (aclk),
        .areset      (areset),
        .aw_idx      (s_axi_awaddr[ADDR_WIDTH-1:2]),
        .awvalid     (s_axi_awvalid),
        .awready     (s_axi_awready),
        .wdata       (s_axi_wdata),
        .wstrb       (s_axi_wstrb),
        .wvalid      (s_axi_wvalid),
        .wready      (s_axi_wready),
        .bvalid      (bvalid_reg),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    assign wr_idx32   = 32'(commit_idx);
    assign wr_cfg_hit = (wr_idx32 < CFG_LIM);

    // One register per config word, updated lane-by-lane on its commit.
    for (genvar gi = 0; gi < CFG_WORDS; gi++) begin : g_cfg
        logic [AXI_DATA_W-1:0] word_reg;

        assign wr_sel[gi] = commit && wr_cfg_hit && (wr_idx32 == gi);
        assign cfg_data[AXI_DATA_W*gi +: AXI_DATA_W] = word_reg;

        // Byte-merge the committed data into this word.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                word_reg <= '0;
            end else if (wr_sel[gi]) begin
                word_reg <= byte_merge(word_reg, commit_data, commit_strb);
            end
        end
    end

    // Strobe pulses alongside the updated word; an all-zero wstrb is silent.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cfg_wr_stb_reg <= '0;
        end else begin
            cfg_wr_stb_reg <= (commit_strb != '0) ? wr_sel : '0;
        end
    end

    assign cfg_wr_stb = cfg_wr_stb_reg;

    // Write response: raised on commit, held until bready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_reg <= 1'b1;
            bresp_reg  <= wr_cfg_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_reg && s_axi_bready) begin
            bvalid_reg <= 1'b0;
        end
    end

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;

    assign rd_idx32 = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

    // Read decode; config words read the pre-commit register value.
    always_comb begin
        rd_word = '0;
        rd_resp = RESP_SLVERR;
        if (rd_idx32 < CFG_LIM) begin
            rd_resp = RESP_OKAY;
            for (int k = 0; k < CFG_WORDS; k++) begin
                if (rd_idx32 == 32'(k)) begin
                    rd_word = cfg_data[AXI_DATA_W*k +: AXI_DATA_W];
                end
            end
        end else if (rd_idx32 >= STS_BASE && rd_idx32 < STS_LIM) begin
            rd_resp = RESP_OKAY;
            for (int k = 0; k < STS_WORDS; k++) begin
                if (rd_idx32 == STS_BASE + 32'(k)) begin
                    rd_word = sts_data[AXI_DATA_W*k +: AXI_DATA_W];
                end
            end
        end
    end

    assign s_axi_arready = !areset && !rvalid_reg;

    // Read response: sampled at the AR handshake, held until rready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_word;
            rresp_reg  <= rd_resp;
        end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rdata  = rdata_reg;
    assign s_axi_rresp  = rresp_reg;

endmodule

// File: tb/tb_kiwi_axi_cfg_responder.sv
// Directed bench for kiwi_axi_cfg_responder.
module tb_kiwi_axi_cfg_responder;

    localparam int AW = 12;
    localparam int NC = 16;
    localparam int NS = 8;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [AW-1:0]   s_axi_awaddr = '0;
    logic            s_axi_awvalid = 1'b0;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata = '0;
    logic [3:0]      s_axi_wstrb = '0;
    logic            s_axi_wvalid = 1'b0;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready = 1'b0;
    logic [AW-1:0]   s_axi_araddr = '0;
    logic            s_axi_arvalid = 1'b0;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready = 1'b0;
    logic [32*NC-1:0] cfg_data;
    logic [NC-1:0]   cfg_wr_stb;
    logic [32*NS-1:0] sts_data = '0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_cfg [NC];

    kiwi_axi_cfg_responder #(
        .ADDR_WIDTH (AW),
        .CFG_WORDS  (NC),
        .STS_WORDS  (NS),
        .STS_OFFSET (32'h800)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .cfg_data      (cfg_data),
        .cfg_wr_stb    (cfg_wr_stb),
        .sts_data      (sts_data)
    );

    always #5 aclk = ~aclk;

    function automatic logic [32*NC-1:0] exp_flat();
        logic [32*NC-1:0] f;
        for (int k = 0; k < NC; k++) f[32*k +: 32] = exp_cfg[k];
        return f;
    endfunction

    // Same-cycle AW+W write, bounded wait for B, then B handshake.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [NC-1:0] stb, output bit timeout);
        int  cyc;
        bit  aw_hs, w_hs;
        cyc = 0;
        timeout = 1'b0;
        stb = '0;
        resp = 2'bxx;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        while ((s_axi_awvalid || s_axi_wvalid) && cyc < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(negedge aclk); cyc++;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid = 1'b0;
        end
        while (!s_axi_bvalid && cyc < 20) begin
            @(negedge aclk); cyc++;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        if (!s_axi_bvalid) begin
            timeout = 1'b1;
        end else begin
            resp = s_axi_bresp;
            stb  = cfg_wr_stb;
            s_axi_bready = 1'b1;
            @(negedge aclk);
            s_axi_bready = 1'b0;
        end
        $display("[TB] write addr=0x%03h data=0x%08h strb=%b resp=%b stb=0x%04h", addr, data, strb, resp, stb);
    endtask

    // AR handshake, bounded wait for R, then R handshake.
    task automatic do_read(input logic [AW-1:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit timeout);
        int cyc;
        bit ar_hs;
        cyc = 0;
        timeout = 1'b0;
        data = 'x; resp = 2'bxx;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (s_axi_arvalid && cyc < 20) begin
            ar_hs = s_axi_arready;
            @(negedge aclk); cyc++;
            if (ar_hs) s_axi_arvalid = 1'b0;
        end
        while (!s_axi_rvalid && cyc < 20) begin
            @(negedge aclk); cyc++;
        end
        s_axi_arvalid = 1'b0;
        if (!s_axi_rvalid) begin
            timeout = 1'b1;
        end else begin
            data = s_axi_rdata; resp = s_axi_rresp;
            s_axi_rready = 1'b1;
            @(negedge aclk);
            s_axi_rready = 1'b0;
        end
        $display("[TB] read addr=0x%03h data=0x%08h resp=%b", addr, data, resp);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (5) @(negedge aclk);
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_readies_low: got %b want 000", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        areset = 1'b0;
        @(negedge aclk);
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_readies_high: got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        tests_run++;
        if (cfg_data !== exp_flat() || cfg_wr_stb !== '0) begin
            tests_failed++;
            $display("FAIL reset_cfg: got cfg0=0x%08h stb=0x%04h want 0", cfg_data[31:0], cfg_wr_stb);
        end
        tests_run++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 6'b0 || s_axi_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_resp: got bv=%b rv=%b br=%b rr=%b rd=0x%08h want zeros",
                     s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, s_axi_rdata);
        end
        $display("[TB] reset released");
    endtask

    task automatic test_aw_first();
        @(negedge aclk);
        s_axi_awaddr = 12'h004; s_axi_awvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        repeat (3) begin
            tests_run++;
            if (s_axi_awready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL awfirst_awready_held: got awready=%b bvalid=%b want 0 0", s_axi_awready, s_axi_bvalid);
            end
            @(negedge aclk);
        end
        s_axi_wdata = 32'h170A3D71; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tests_run++;
        if (s_axi_wready !== 1'b1) begin
            tests_failed++;
            $display("FAIL awfirst_wready: got %b want 1", s_axi_wready);
        end
        @(negedge aclk);
        s_axi_wvalid = 1'b0;
        tests_run++;
        if (cfg_data[63:32] !== 32'h0 || s_axi_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL awfirst_early: got word1=0x%08h bvalid=%b want 0 0", cfg_data[63:32], s_axi_bvalid);
        end
        @(negedge aclk);
        exp_cfg[1] = 32'h170A3D71;
        tests_run++;
        if (cfg_data !== exp_flat() || cfg_wr_stb !== 16'h0002) begin
            tests_failed++;
            $display("FAIL awfirst_commit: got word1=0x%08h stb=0x%04h want 0x170a3d71 0x0002", cfg_data[63:32], cfg_wr_stb);
        end
        tests_run++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            tests_failed++;
            $display("FAIL awfirst_bresp: got bvalid=%b bresp=%b want 1 00", s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        tests_run++;
        if (cfg_wr_stb !== 16'h0 || s_axi_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL awfirst_after: got stb=0x%04h bvalid=%b want 0 0", cfg_wr_stb, s_axi_bvalid);
        end
        $display("[TB] write addr=0x004 aw-first done");
    endtask

    task automatic test_partial_strobe();
        logic [1:0] resp; logic [NC-1:0] stb; bit to;
        do_write(12'h000, 32'hAABBCCDD, 4'hF, resp, stb, to);
        exp_cfg[0] = 32'hAABBCCDD;
        do_write(12'h000, 32'h0000000F, 4'b0011, resp, stb, to);
        exp_cfg[0] = 32'hAABB000F;
        tests_run++;
        if (to || cfg_data !== exp_flat()) begin
            tests_failed++;
            $display("FAIL partial_word0: got 0x%08h timeout=%0d want 0xaabb000f", cfg_data[31:0], to);
        end
        tests_run++;
        if (stb !== 16'h0001 || resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL partial_stb: got stb=0x%04h resp=%b want 0x0001 00", stb, resp);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge aclk);
        s_axi_awaddr = 12'h024; s_axi_wdata = 32'h8; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tests_run++;
        if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL same_readies: got %b want 11", {s_axi_awready, s_axi_wready});
        end
        @(negedge aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tests_run++;
        if (cfg_data[32*9 +: 32] !== 32'h0) begin
            tests_failed++;
            $display("FAIL same_early: got word9=0x%08h want 0", cfg_data[32*9 +: 32]);
        end
        @(negedge aclk);
        exp_cfg[9] = 32'h8;
        tests_run++;
        if (cfg_data !== exp_flat() || cfg_wr_stb !== 16'h0200 || s_axi_bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_commit: got word9=0x%08h stb=0x%04h bvalid=%b want 8 0x0200 1",
                     cfg_data[32*9 +: 32], cfg_wr_stb, s_axi_bvalid);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        $display("[TB] write addr=0x024 same-cycle done");
    endtask

    task automatic test_status_read();
        sts_data[31:0]  = 32'hCAFE0000;
        sts_data[63:32] = 32'h00000123;
        sts_data[32*7 +: 32] = 32'h0BADF00D;
        @(negedge aclk);
        s_axi_araddr = 12'h804; s_axi_arvalid = 1'b1;
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        sts_data[63:32] = 32'h00000999;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h123 || s_axi_rresp !== 2'b00 || s_axi_arready !== 1'b0) begin
                tests_failed++;
                $display("FAIL sts_hold[%0d]: got rv=%b rd=0x%08h rr=%b ar=%b want 1 0x00000123 00 0",
                         i, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready);
            end
            @(negedge aclk);
        end
        s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_rready = 1'b0;
        tests_run++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sts_release: got rv=%b ar=%b want 0 1", s_axi_rvalid, s_axi_arready);
        end
        $display("[TB] read addr=0x804 backpressured done");
    endtask

    task automatic test_reads();
        logic [31:0] d; logic [1:0] r; bit to;
        do_read(12'h004, d, r, to);
        tests_run++;
        if (to || d !== 32'h170A3D71 || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_cfg1: got 0x%08h resp=%b want 0x170a3d71 00", d, r);
        end
        do_read(12'h81C, d, r, to);
        tests_run++;
        if (to || d !== 32'h0BADF00D || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_sts7: got 0x%08h resp=%b want 0x0badf00d 00", d, r);
        end
    endtask

    task automatic test_errors();
        logic [1:0] resp; logic [NC-1:0] stb; bit to;
        logic [31:0] d; logic [1:0] r;
        do_write(12'h800, 32'hDEADBEEF, 4'hF, resp, stb, to);
        tests_run++;
        if (to || resp !== 2'b10 || stb !== '0 || cfg_data !== exp_flat()) begin
            tests_failed++;
            $display("FAIL err_wr_sts: got resp=%b stb=0x%04h cfg_ok=%0d want 10 0 1", resp, stb, cfg_data === exp_flat());
        end
        do_read(12'h040, d, r, to);
        tests_run++;
        if (to || d !== 32'h0 || r !== 2'b10) begin
            tests_failed++;
            $display("FAIL err_rd_040: got 0x%08h resp=%b want 0 10", d, r);
        end
        do_read(12'h7FC, d, r, to);
        tests_run++;
        if (to || d !== 32'h0 || r !== 2'b10) begin
            tests_failed++;
            $display("FAIL err_rd_7fc: got 0x%08h resp=%b want 0 10", d, r);
        end
        do_read(12'h820, d, r, to);
        tests_run++;
        if (to || d !== 32'h0 || r !== 2'b10) begin
            tests_failed++;
            $display("FAIL err_rd_820: got 0x%08h resp=%b want 0 10", d, r);
        end
    endtask

    task automatic test_bresp_reset();
        logic [1:0] resp; logic [NC-1:0] stb; bit to;
        @(negedge aclk);
        s_axi_awaddr = 12'h00C; s_axi_wdata = 32'h11112222; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (2) @(negedge aclk);
        s_axi_awaddr = 12'h008; s_axi_wdata = 32'h33334444;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        repeat (3) begin
            tests_run++;
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_blocked: got bv=%b aw=%b w=%b want 1 0 0", s_axi_bvalid, s_axi_awready, s_axi_wready);
            end
            @(negedge aclk);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        areset = 1'b1;
        #1;
        tests_run++;
        if (s_axi_bvalid !== 1'b0 || {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL bp_reset: got bv=%b readies=%b want 0 000", s_axi_bvalid, {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        for (int k = 0; k < NC; k++) exp_cfg[k] = 32'h0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        do_write(12'h008, 32'h33334444, 4'hF, resp, stb, to);
        exp_cfg[2] = 32'h33334444;
        tests_run++;
        if (to || resp !== 2'b00 || stb !== 16'h0004 || cfg_data !== exp_flat()) begin
            tests_failed++;
            $display("FAIL bp_after_reset: got resp=%b stb=0x%04h word2=0x%08h timeout=%0d want 00 0x0004 0x33334444",
                     resp, stb, cfg_data[95:64], to);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; logic [NC-1:0] stb; bit to;
        do_write(12'h014, 32'h00000001, 4'hF, resp, stb, to);
        exp_cfg[5] = 32'h1;
        @(negedge aclk);
        s_axi_awaddr = 12'h014; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge aclk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 12'h014; s_axi_arvalid = 1'b1;
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        exp_cfg[5] = 32'h55;
        tests_run++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1 || cfg_data !== exp_flat()) begin
            tests_failed++;
            $display("FAIL rw_collide: got rv=%b rd=0x%08h word5=0x%08h want 1 0x00000001 0x00000055",
                     s_axi_rvalid, s_axi_rdata, cfg_data[32*5 +: 32]);
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        $display("[TB] read/write collision on 0x014 done");
    endtask

    initial begin
        for (int k = 0; k < NC; k++) exp_cfg[k] = 32'h0;
        test_reset();
        test_aw_first();
        test_partial_strobe();
        test_same_cycle();
        test_status_read();
        test_reads();
        test_errors();
        test_bresp_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
